// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display bank: register map, reset values,
// the active-high hex glyph ROM and the bus request bundle.
package seven_seg_pkg;

    localparam logic [3:0]  ADDR_CTRL     = 4'h8;
    localparam logic [3:0]  ADDR_HEX      = 4'h9;
    localparam logic [3:0]  ADDR_BLINKCNT = 4'hA;

    localparam logic [4:0]  CODE_BLANK    = 5'h10;
    localparam logic [31:0] CTRL_RESET    = 32'h0000_0001;

    // Bit order g..a; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] GLYPH_ROM = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [3:0]  address;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational digit decoder: 5-bit code plus external blank to an active-high
// g..a segment pattern. Code bit4 blanks the digit on its own.
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [4:0] code,
    input  logic       blank,
    output logic [6:0] pattern
);

    assign pattern = (blank || code[4]) ? 7'h00 : GLYPH_ROM[code[3:0]];

endmodule

// File: rtl/seven_seg_array.sv
// Avalon-MM controller for a bank of seven-segment digits with per-digit codes,
// packed-hex writes, global enable and prescaled per-digit blinking.
module seven_seg_array
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic                    read,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] segs
);

    localparam int                    CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]         CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [7*NUM_DIGITS-1:0] SEGS_OFF = {(7*NUM_DIGITS){ACTIVE_LOW != 0}};

    bus_req_t                       req;
    logic [NUM_DIGITS-1:0][4:0]     digit_q;
    logic                           ctrl_en;
    logic [7:0]                     blink_mask;
    logic [CW-1:0]                  blink_cnt;
    logic                           blink_phase;
    logic [NUM_DIGITS-1:0][6:0]     pat;
    logic [7*NUM_DIGITS-1:0]        segs_d;
    logic [31:0]                    rd_mux;
    logic                           unused_wdata;

    assign req.address = address;
    assign req.wr      = chipselect && write;
    assign req.rd      = chipselect && read;
    assign req.wdata   = writedata;

    // Only some write-data bits are stored; the rest are deliberately dropped.
    assign unused_wdata = ^req.wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q    <= {NUM_DIGITS{CODE_BLANK}};
            ctrl_en    <= CTRL_RESET[0];
            blink_mask <= CTRL_RESET[15:8];
        end else if (req.wr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (req.address == 4'(i))
                    digit_q[i] <= req.wdata[4:0];
                else if (req.address == ADDR_HEX)
                    digit_q[i] <= {1'b0, req.wdata[4*i +: 4]};
            end
            if (req.address == ADDR_CTRL) begin
                ctrl_en    <= req.wdata[0];
                blink_mask <= req.wdata[15:8];
            end
        end
    end

    // Free-running prescaler; unaffected by enable or bus traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic blank;
        assign blank = !ctrl_en || (blink_mask[i] && blink_phase);

        seven_seg_glyph u_glyph (
            .code    (digit_q[i]),
            .blank   (blank),
            .pattern (pat[i])
        );

        assign segs_d[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat[i] : pat[i];
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (req.address == 4'(i))
                rd_mux = {27'b0, digit_q[i]};
        case (req.address)
            ADDR_CTRL:     rd_mux = {16'b0, blink_mask, 7'b0, ctrl_en};
            ADDR_BLINKCNT: rd_mux = 32'(blink_cnt);
            default:       ;
        endcase
    end

    // readdata holds between reads; a same-cycle write is not visible yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else if (req.rd)
            readdata <= rd_mux;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            segs <= SEGS_OFF;
        else
            segs <= segs_d;
    end

endmodule

// File: tb/tb_seven_seg_array.sv
// Directed bench for seven_seg_array: a register-level model predicts pins and
// read data every cycle, and literal checks pin the expected glyphs and values.
module tb_seven_seg_array;

    localparam int ND = 6;
    localparam int BD = 4;

    logic            clk        = 1'b0;
    logic            reset      = 1'b1;
    logic [3:0]      address    = '0;
    logic            chipselect = 1'b0;
    logic            write      = 1'b0;
    logic            read       = 1'b0;
    logic [31:0]     writedata  = '0;
    logic [31:0]     readdata;
    logic [7*ND-1:0] segs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seven_seg_array #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .writedata  (writedata),
        .readdata   (readdata),
        .segs       (segs)
    );

    // Active-high glyphs, g..a
    logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [4:0]      m_code [ND];
    logic            m_en;
    logic [7:0]      m_mask;
    int              m_cnt;
    logic            m_phase;
    logic [7*ND-1:0] m_segs;
    logic [31:0]     m_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7*ND-1:0] pin_image();
        logic [7*ND-1:0] s;
        logic lit;
        s = '1;
        for (int i = 0; i < ND; i++) begin
            lit = m_en && !m_code[i][4] && !(m_mask[i] && m_phase);
            s[7*i +: 7] = lit ? ~glyph_hi[m_code[i][3:0]] : 7'h7F;
        end
        return s;
    endfunction

    function automatic logic [31:0] reg_value(input logic [3:0] a);
        if (int'(a) < ND) return {27'b0, m_code[int'(a)]};
        if (a == 4'h8)    return {16'b0, m_mask, 7'b0, m_en};
        if (a == 4'hA)    return 32'(m_cnt);
        return 32'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ND; i++) m_code[i] <= 5'h10;
            m_en    <= 1'b1;
            m_mask  <= 8'h00;
            m_cnt   <= 0;
            m_phase <= 1'b0;
            m_segs  <= '1;
            m_rd    <= 32'h0;
        end else begin
            m_segs <= pin_image();
            if (chipselect && read) m_rd <= reg_value(address);
            if (chipselect && write) begin
                if (int'(address) < ND)
                    m_code[int'(address)] <= writedata[4:0];
                else if (address == 4'h9)
                    for (int i = 0; i < ND; i++) m_code[i] <= {1'b0, writedata[4*i +: 4]};
                else if (address == 4'h8) begin
                    m_en   <= writedata[0];
                    m_mask <= writedata[15:8];
                end
            end
            m_cnt <= (m_cnt + 1) % BD;
            if (m_cnt == BD - 1) m_phase <= ~m_phase;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("segs_model", 64'(segs), 64'(m_segs));
            chk("readdata_model", 64'(readdata), 64'(m_rd));
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] cv [4];
        int lit0, lit1;

        repeat (3) @(negedge clk);
        chk("reset_segs", 64'(segs), 64'({(7*ND){1'b1}}));
        chk("reset_readdata", 64'(readdata), 64'h0);
        reset = 1'b0;

        bus_rd(4'h8, v); chk("ctrl_reset", 64'(v), 64'h1);
        bus_rd(4'h0, v); chk("digit0_reset", 64'(v), 64'h10);

        bus_wr(4'h2, 32'h1);
        @(negedge clk);
        chk("digit2_pins", 64'(segs[20:14]), 64'(7'b1111001));
        bus_rd(4'h2, v); chk("digit2_read", 64'(v), 64'h1);

        bus_wr(4'h9, 32'h00AB_CDEF);
        @(negedge clk);
        chk("hex_digit0_F", 64'(segs[6:0]), 64'(7'b0001110));
        chk("hex_digit5_A", 64'(segs[41:35]), 64'(7'b0001000));
        for (int n = 0; n < ND; n++) begin
            bus_rd(4'(n), v);
            chk("hex_digit_read", 64'(v), 64'(15 - n));
        end

        bus_wr(4'h8, 32'h0);
        @(negedge clk);
        chk("disable_blank", 64'(segs), 64'({(7*ND){1'b1}}));

        bus_wr(4'h8, 32'h0101);
        @(negedge clk);
        lit0 = 0; lit1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (segs[6:0] != 7'h7F) lit0++;
            if (segs[13:7] == 7'b0000110) lit1++;
        end
        chk("blink_digit0_lit", 64'(lit0), 64'd4);
        chk("blink_digit1_lit", 64'(lit1), 64'd8);

        address = 4'hA; chipselect = 1'b1; read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cv[k] = readdata;
        end
        chipselect = 1'b0; read = 1'b0;
        for (int k = 1; k < 4; k++)
            chk("blinkcnt_step", 64'(cv[k]), 64'((cv[k-1] + 1) % BD));

        bus_wr(4'h1, 32'h3);
        address = 4'h1; writedata = 32'h7; chipselect = 1'b1; write = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        chk("rw_same_cycle_old", 64'(readdata), 64'h3);
        bus_rd(4'h1, v); chk("rw_same_cycle_new", 64'(v), 64'h7);

        bus_wr(4'hA, 32'h3);
        bus_wr(4'hB, 32'h5);
        bus_wr(4'h7, 32'h2);
        bus_wr(4'h6, 32'h2);
        bus_rd(4'h9, v); chk("hex_reads_zero", 64'(v), 64'h0);
        bus_rd(4'h6, v); chk("digit6_absent", 64'(v), 64'h0);
        bus_rd(4'hB, v); chk("unmapped_zero", 64'(v), 64'h0);

        bus_wr(4'h8, 32'hFFFF_FFFF);
        bus_rd(4'h8, v); chk("ctrl_stored_bits", 64'(v), 64'hFF01);
        repeat (6) @(negedge clk);

        bus_wr(4'h8, 32'h0101);
        bus_rd(4'h8, v); chk("ctrl_blink", 64'(v), 64'h101);
        repeat (3) @(negedge clk);

        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_segs", 64'(segs), 64'({(7*ND){1'b1}}));
        chk("async_reset_readdata", 64'(readdata), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        address = 4'hA; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        chk("blinkcnt_after_reset", 64'(readdata), 64'h0);
        bus_rd(4'h8, v); chk("ctrl_after_reset", 64'(v), 64'h1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_array.md
# seven_seg_array

Memory-mapped controller for a bank of `NUM_DIGITS` seven-segment displays on the Avalon-MM peripheral bus. It holds one 5-bit code per digit, plus a packed-hex write port, a global enable and a per-digit blink mask driven by an internal prescaler. All registers can be read back. It drives registered segment outputs directly to the board pins and replaces single-digit, write-only decoders.

## Interface
- `NUM_DIGITS`, 6, number of digits driven; legal 1..8.
- `BLINK_DIV`, 25_000_000, clk cycles per blink half-period; legal ≥ 2.
- `ACTIVE_LOW`, 1, 1 = segment lit when output bit is 0; 0 inverts all `segs` bits.
- `clk` input 1: system clock, all logic rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 4: word address.
- `chipselect` input 1: slave select; `write`/`read` ignored when low.
- `write` input 1: write strobe.
- `read` input 1: read strobe.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data.
- `segs` output 7*NUM_DIGITS: digit i on bits [7i+6:7i], bit order g..a (bit 6 = g).

## Operation
- Register map:
  - 0..NUM_DIGITS-1 DIGITn: [4:0] code, with 0x00–0x0F = hex glyph and bit4 = 1 blank.
  - 0x8 CTRL: [0] enable, [15:8] blink mask (bit i → digit i).
  - 0x9 HEX: write-only packed value, digit i ← {1'b0, writedata[4i+3:4i]} for i < NUM_DIGITS.
  - 0xA BLINKCNT: read-only, the current prescaler count.
- Reset values:
  - Every DIGITn = 5'h10.
  - CTRL = 0x0000_0001.
  - Prescaler = 0 and blink phase = 0.
  - `readdata` = 0.
  - `segs` = all segments off (all 1s when ACTIVE_LOW = 1).
- Writes: a write to an unmapped address, to BLINKCNT, or to DIGITn with n ≥ NUM_DIGITS is ignored. CTRL bits outside [15:8] and [0] are not stored. Mask bits ≥ NUM_DIGITS are stored but have no effect.
- Reads: 0x9 and unmapped addresses return 0. Unused bits return 0. DIGITn reads zero-extend the code.
- Glyphs use standard hex patterns:
  - 0 = a,b,c,d,e,f on, g off.
  - 8 = all on.
  - A, b, C, d, E, F are upper/lower case as on the existing hex displays.
- Digit i is blanked when any of the following holds: enable = 0; code bit4 = 1; mask[i] = 1 and blink phase = 1.
- Prescaler: counts 0..BLINK_DIV-1 and wraps to 0. Blink phase toggles on each wrap. It runs freely regardless of enable and writes.

## Timing
- Writes take effect at the `clk` edge where `chipselect && write` is sampled. `segs` reflects the new value one edge later, so write-to-pin latency is 2 edges.
- Read latency is 1: `readdata` is valid on the edge after `chipselect && read` is sampled. It holds its value until the next read.
- Simultaneous `read` and `write` in one cycle: the write commits, and `readdata` returns the pre-write value.
- Blink phase toggles on the edge where the count goes BLINK_DIV-1 → 0. `segs` follows one edge later.
- Reset asserted mid-operation: all state returns immediately and asynchronously to its reset values, including `segs`. Operation restarts on the first edge after deassertion.

## Structure
- Package `seven_seg_pkg` holds:
  - Address constants ADDR_CTRL, ADDR_HEX, ADDR_BLINKCNT.
  - CODE_BLANK = 5'h10.
  - CTRL reset constant.
  - The 16-entry glyph constant, active-high.
- Sub-module `seven_seg_glyph`: a combinational 5-bit code + blank → 7-bit active-high pattern. It is instantiated NUM_DIGITS times in a generate loop. Polarity is applied in the top level before the `segs` register.
- Prescaler and blink phase live in the top level. Counter width is $clog2(BLINK_DIV).

## Test plan
- Reset: with NUM_DIGITS = 6, hold `reset` for 3 cycles → `segs` = all 1s, CTRL read = 0x1, DIGIT0 read = 0x10.
- Write 0x1 to DIGIT2 → two edges later `segs[20:14]` = 7'b1111001. Read DIGIT2 → `readdata` = 0x1 one edge after the read.
- Write 0x00ABCDEF to HEX → digits 0..5 show F, E, D, C, B, A; each DIGITn read = 0x0n-nibble. Then write 0x0 to CTRL → all digits are blanked within 2 edges.
- With BLINK_DIV = 4, write CTRL = 0x0101 → digit 0 alternates lit/off every 4 cycles while digits 1..5 stay lit. BLINKCNT reads cycle 0, 1, 2, 3.
- Assert `read` and `write` to DIGIT1 in the same cycle (old 0x3, new 0x7) → `readdata` = 0x3, and a subsequent read returns 0x7.
- Assert `reset` asynchronously mid-blink, between clock edges → `segs` goes all off and `readdata` goes to 0 without waiting for a clock edge, and BLINKCNT reads 0 after release.
